// File: rtl/vfifo_ram_pkg.sv
// Shared definitions for the vfifo dual-port RAM: read-during-write mode
// constants, the clear-engine state encoding and the byte parity helper.
package vfifo_ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Even parity: the stored bit makes the byte plus parity an even count of ones
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/vfifo_ram_clr_fsm.sv
// Clear engine for the vfifo dual-port RAM. Walks every address once,
// writing CLR_VALUE, and owns the port A write mux while it runs.
// The FSM state is the busy flag and is exported on dbg_state.
module vfifo_ram_clr_fsm
    import vfifo_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    CLR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    input  logic                      we_a,
    input  logic [DATA_WIDTH/8-1:0]   be_a,
    input  logic [ADDR_WIDTH-1:0]     adr_a,
    input  logic [DATA_WIDTH-1:0]     d_a,
    output clr_state_t                dbg_state,
    output logic [DATA_WIDTH/8-1:0]   wr_mask,
    output logic [ADDR_WIDTH-1:0]     wr_adr,
    output logic [DATA_WIDTH-1:0]     wr_data
);

    localparam int         NB        = DATA_WIDTH / 8;
    localparam clr_state_t RST_STATE = (CLR_ON_RST != 0) ? CLR_RUN : CLR_IDLE;

    clr_state_t            state;
    clr_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;

    // State register; reset lands directly in CLR_RUN when auto-clear is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // Address counter: advances while clearing, parked at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (state == CLR_RUN) cnt <= cnt + ADDR_WIDTH'(1);
        else                       cnt <= '0;
    end

    // Next state: start on request when idle, stop after the top address
    always_comb begin
        state_nxt = state;
        case (state)
            CLR_IDLE: if (clr_req)   state_nxt = CLR_RUN;
            CLR_RUN:  if (&cnt)      state_nxt = CLR_IDLE;
            default:                 state_nxt = CLR_IDLE;
        endcase
    end

    // Outputs: port A write mux selects the clear engine while running
    always_comb begin
        dbg_state = state;
        wr_mask   = we_a ? be_a : '0;
        wr_adr    = adr_a;
        wr_data   = d_a;
        if (state == CLR_RUN) begin
            wr_mask = {NB{1'b1}};
            wr_adr  = cnt;
            wr_data = CLR_VALUE;
        end
    end

endmodule

// File: rtl/vfifo_dual_port_ram_sc_be.sv
// Single-clock true dual-port RAM with byte enables, read valids,
// selectable same-port read-during-write, optional output register and
// a sequential clear engine. Optional per-byte parity is enabled by
// defining VFIFO_RAM_PARITY_EN; without it perr_a/perr_b stay 0.
module vfifo_dual_port_ram_sc_be
    import vfifo_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter int                    CLR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic [DATA_WIDTH-1:0]   d_a,
    input  logic [DATA_WIDTH-1:0]   d_b,
    input  logic [ADDR_WIDTH-1:0]   adr_a,
    input  logic [ADDR_WIDTH-1:0]   adr_b,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic                    we_a,
    input  logic                    we_b,
    input  logic                    re_a,
    input  logic                    re_b,
    output logic [DATA_WIDTH-1:0]   q_a,
    output logic [DATA_WIDTH-1:0]   q_b,
    output logic                    qv_a,
    output logic                    qv_b,
    output logic                    perr_a,
    output logic                    perr_b
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_t            clr_state;
    logic                  busy_i;
    logic [NB-1:0]         wm_a, wm_b, um_a;
    logic [ADDR_WIDTH-1:0] wadr_a;
    logic [DATA_WIDTH-1:0] wd_a;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic                  pe_now_a, pe_now_b;
    logic [DATA_WIDTH-1:0] q1_a, q1_b;
    logic                  qv1_a, qv1_b, pe1_a, pe1_b;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [NB-1:0]         mask);
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    vfifo_ram_clr_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CLR_ON_RST (CLR_ON_RST),
        .CLR_VALUE  (CLR_VALUE)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .we_a      (we_a),
        .be_a      (be_a),
        .adr_a     (adr_a),
        .d_a       (d_a),
        .dbg_state (clr_state),
        .wr_mask   (wm_a),
        .wr_adr    (wadr_a),
        .wr_data   (wd_a)
    );

    assign busy_i = (clr_state == CLR_RUN);
    assign busy   = busy_i;
    // User byte masks; both are dropped while the clear engine owns the array
    assign um_a   = (we_a && !busy_i) ? be_a : '0;
    assign wm_b   = (we_b && !busy_i) ? be_b : '0;

    // Array write: port B is applied first so port A wins on overlapping bytes
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wm_b[i]) mem[adr_b][8*i +: 8]  <= d_b[8*i +: 8];
            if (wm_a[i]) mem[wadr_a][8*i +: 8] <= wd_a[8*i +: 8];
        end
    end

    // Read data: stored word, same-port write-first bypass, forced to zero while clearing
    always_comb begin
        rd_a = mem[adr_a];
        rd_b = mem[adr_b];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            rd_a = merge_bytes(rd_a, d_a, um_a);
            rd_b = merge_bytes(rd_b, d_b, wm_b);
        end
        if (busy_i) begin
            rd_a = '0;
            rd_b = '0;
        end
    end

`ifdef VFIFO_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rp_a, rp_b;

    function automatic logic [NB-1:0] word_parity(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = byte_parity(w[8*i +: 8]);
        return p;
    endfunction

    // Parity write follows the data write, including the clear engine path
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wm_b[i]) par[adr_b][i]  <= byte_parity(d_b[8*i +: 8]);
            if (wm_a[i]) par[wadr_a][i] <= byte_parity(wd_a[8*i +: 8]);
        end
    end

    // Parity check on the word actually returned, bypassed bytes included
    always_comb begin
        rp_a = par[adr_a];
        rp_b = par[adr_b];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            rp_a = (rp_a & ~um_a) | (word_parity(d_a) & um_a);
            rp_b = (rp_b & ~wm_b) | (word_parity(d_b) & wm_b);
        end
        pe_now_a = !busy_i && (word_parity(rd_a) != rp_a);
        pe_now_b = !busy_i && (word_parity(rd_b) != rp_b);
    end
`else
    assign pe_now_a = 1'b0;
    assign pe_now_b = 1'b0;
`endif

    // First read stage: q holds when not reading, valid and parity follow re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a  <= '0;   q1_b  <= '0;
            qv1_a <= 1'b0; qv1_b <= 1'b0;
            pe1_a <= 1'b0; pe1_b <= 1'b0;
        end else begin
            qv1_a <= re_a;
            qv1_b <= re_b;
            pe1_a <= re_a & pe_now_a;
            pe1_b <= re_b & pe_now_b;
            if (re_a) q1_a <= rd_a;
            if (re_b) q1_b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q2_a, q2_b;
            logic                  qv2_a, qv2_b, pe2_a, pe2_b;

            // Second read stage: data, valid and parity advance together
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a  <= '0;   q2_b  <= '0;
                    qv2_a <= 1'b0; qv2_b <= 1'b0;
                    pe2_a <= 1'b0; pe2_b <= 1'b0;
                end else begin
                    qv2_a <= qv1_a;
                    qv2_b <= qv1_b;
                    pe2_a <= pe1_a;
                    pe2_b <= pe1_b;
                    if (qv1_a) q2_a <= q1_a;
                    if (qv1_b) q2_b <= q1_b;
                end
            end

            assign q_a = q2_a;   assign q_b = q2_b;
            assign qv_a = qv2_a; assign qv_b = qv2_b;
            assign perr_a = pe2_a; assign perr_b = pe2_b;
        end else begin : g_noreg
            assign q_a = q1_a;   assign q_b = q1_b;
            assign qv_a = qv1_a; assign qv_b = qv1_b;
            assign perr_a = pe1_a; assign perr_b = pe1_b;
        end
    endgenerate

endmodule

// File: tb/tb_vfifo_dual_port_ram_sc_be.sv
// Bench for vfifo_dual_port_ram_sc_be. Two instances share one stimulus:
// dut0 is write-first with latency 1, dut1 is read-first with latency 2.
// Read streams: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
module tb_vfifo_dual_port_ram_sc_be;

    localparam int             DW    = 32;
    localparam int             AW    = 4;
    localparam int             NB    = 4;
    localparam int             DEPTH = 16;
    localparam logic [DW-1:0]  CLR_VAL = 32'h5A5A_0F0F;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_req;
    logic [DW-1:0] d_a, d_b;
    logic [AW-1:0] adr_a, adr_b;
    logic [NB-1:0] be_a, be_b;
    logic          we_a, we_b, re_a, re_b;

    logic          busy0, busy1;
    logic [DW-1:0] q0_a, q0_b, q1_a, q1_b;
    logic          qv0_a, qv0_b, qv1_a, qv1_b;
    logic          pe0_a, pe0_b, pe1_a, pe1_b;

    // Clock
    always #5 clk = ~clk;

    vfifo_dual_port_ram_sc_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0),
        .CLR_ON_RST(1), .CLR_VALUE(CLR_VAL)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy0),
        .d_a(d_a), .d_b(d_b), .adr_a(adr_a), .adr_b(adr_b),
        .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b),
        .re_a(re_a), .re_b(re_b), .q_a(q0_a), .q_b(q0_b),
        .qv_a(qv0_a), .qv_b(qv0_b), .perr_a(pe0_a), .perr_b(pe0_b)
    );

    vfifo_dual_port_ram_sc_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1),
        .CLR_ON_RST(1), .CLR_VALUE(CLR_VAL)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy1),
        .d_a(d_a), .d_b(d_b), .adr_a(adr_a), .adr_b(adr_b),
        .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b),
        .re_a(re_a), .re_b(re_b), .q_a(q1_a), .q_b(q1_b),
        .qv_a(qv1_a), .qv_b(qv1_b), .perr_a(pe1_a), .perr_b(pe1_b)
    );

    logic [DW-1:0] q_s  [4];
    logic          qv_s [4];
    logic          pe_s [4];
    assign q_s[0] = q0_a;   assign q_s[1] = q0_b;   assign q_s[2] = q1_a;   assign q_s[3] = q1_b;
    assign qv_s[0] = qv0_a; assign qv_s[1] = qv0_b; assign qv_s[2] = qv1_a; assign qv_s[3] = qv1_b;
    assign pe_s[0] = pe0_a; assign pe_s[1] = pe0_b; assign pe_s[2] = pe1_a; assign pe_s[3] = pe1_b;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            clr_cyc = 0;
    logic [DW-1:0] m       [DEPTH];
    logic          corrupt [DEPTH];
    logic [DW-1:0] last_q  [4];
    // Entry: [63:40] cycle the result is due, [32] expected perr, [31:0] expected q
    logic [63:0]   exp_q   [4][$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected read result for one stream, computed from the model before this cycle's writes
    task automatic push_read(input int s, input logic [AW-1:0] adr, input logic w,
                             input logic [NB-1:0] be, input logic [DW-1:0] d, input logic bsy);
        logic [DW-1:0] v;
        logic          pe;
        v  = '0;
        pe = 1'b0;
        if (!bsy) begin
            v  = m[adr];
            pe = corrupt[adr];
            if (s < 2 && w) begin
                for (int i = 0; i < NB; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
                if (be[0]) pe = 1'b0;
            end
        end
        exp_q[s].push_back({24'(cyc + 1 + ((s >= 2) ? 1 : 0)), 7'b0, pe, v});
    endtask

    // Driver: apply one cycle of stimulus, update the model, advance one clock
    task automatic step(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic [NB-1:0] ba, input logic ra,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        input logic [NB-1:0] bb, input logic rb, input logic cr);
        logic busy_m;
        we_a = wa; adr_a = aa; d_a = da; be_a = ba; re_a = ra;
        we_b = wb; adr_b = ab; d_b = db; be_b = bb; re_b = rb;
        clr_req = cr;
        busy_m = (clr_cyc > 0);
        check("busy0", 32'(busy0), 32'(busy_m));
        check("busy1", 32'(busy1), 32'(busy_m));
        if (ra) begin push_read(0, aa, wa, ba, da, busy_m); push_read(2, aa, wa, ba, da, busy_m); end
        if (rb) begin push_read(1, ab, wb, bb, db, busy_m); push_read(3, ab, wb, bb, db, busy_m); end
        if (!busy_m) begin
            for (int i = 0; i < NB; i++) begin
                if (wb && bb[i]) begin m[ab][8*i +: 8] = db[8*i +: 8]; if (i == 0) corrupt[ab] = 1'b0; end
                if (wa && ba[i]) begin m[aa][8*i +: 8] = da[8*i +: 8]; if (i == 0) corrupt[aa] = 1'b0; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (busy_m) begin
            clr_cyc--;
            if (clr_cyc == 0) for (int i = 0; i < DEPTH; i++) begin m[i] = CLR_VAL; corrupt[i] = 1'b0; end
        end else if (cr) begin
            clr_cyc = DEPTH;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic apply_reset();
        we_a = 0; we_b = 0; re_a = 0; re_b = 0; clr_req = 0;
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) exp_q[s].delete();
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst_q%0d", s), q_s[s], '0);
            check($sformatf("rst_qv%0d", s), 32'(qv_s[s]), '0);
            check($sformatf("rst_pe%0d", s), 32'(pe_s[s]), '0);
        end
        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd1);
        @(posedge clk); #1; cyc++;
        @(posedge clk); #1; cyc++;
        rst_n = 1'b1;
        clr_cyc = DEPTH;
    endtask

    // Scoreboard: compare every stream on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) last_q[s] = '0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                logic        hit;
                logic [63:0] e;
                hit = (exp_q[s].size() > 0) && (exp_q[s][0][63:40] == 24'(cyc));
                check($sformatf("qv%0d", s), 32'(qv_s[s]), 32'(hit));
                if (hit) begin
                    e = exp_q[s].pop_front();
                    check($sformatf("q%0d", s), q_s[s], e[31:0]);
                    check($sformatf("perr%0d", s), 32'(pe_s[s]), 32'(e[32]));
                    last_q[s] = e[31:0];
                end else begin
                    check($sformatf("hold%0d", s), q_s[s], last_q[s]);
                    check($sformatf("perr_idle%0d", s), 32'(pe_s[s]), '0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          wa, wb, ra, rb;
        logic [AW-1:0] aa, ab;
        rst_n = 1'b1; clr_req = 0;
        we_a = 0; we_b = 0; re_a = 0; re_b = 0;
        d_a = '0; d_b = '0; adr_a = '0; adr_b = '0; be_a = '0; be_b = '0;
        for (int i = 0; i < DEPTH; i++) begin m[i] = '0; corrupt[i] = 1'b0; end
        #1;
        apply_reset();

        // Auto-clear after reset; reads during the clear return zero with valid
        for (int i = 0; i < DEPTH; i++)
            step(0, 4'(i), '0, '0, (i % 5) == 0, 0, 4'(i), '0, '0, (i % 7) == 3, 0);

        // Every address holds the clear value
        for (int i = 0; i < DEPTH; i++)
            step(0, 4'(i), '0, '0, 1, 0, 4'(15 - i), '0, '0, 1, 0);

        // Byte-enable write then readback
        step(1, 4'd3, 32'hAABB_CCDD, 4'hF, 0, 0, '0, '0, '0, 0, 0);
        step(1, 4'd3, 32'h1122_3344, 4'h5, 0, 0, '0, '0, '0, 0, 0);
        step(0, 4'd3, '0, '0, 1, 0, 4'd3, '0, '0, 1, 0);

        // Same-port read during write, both ports
        step(1, 4'd5, 32'h0, 4'hF, 0, 1, 4'd6, 32'h0, 4'hF, 0, 0);
        step(1, 4'd5, 32'hFFFF_FFFF, 4'hF, 1, 1, 4'd6, 32'hFFFF_FFFF, 4'hF, 1, 0);
        step(1, 4'd5, 32'h1234_5678, 4'h6, 1, 0, '0, '0, '0, 0, 0);
        step(0, 4'd5, '0, '0, 1, 0, 4'd6, '0, '0, 1, 0);

        // Dual-write collision: A wins on byte 0, B supplies byte 1
        step(1, 4'd7, 32'h0, 4'hF, 0, 0, '0, '0, '0, 0, 0);
        step(1, 4'd7, 32'h0000_00AA, 4'h1, 0, 1, 4'd7, 32'h0000_BBBB, 4'h3, 0, 0);
        step(0, 4'd7, '0, '0, 1, 0, 4'd7, '0, '0, 1, 0);

        // Cross-port write/read of one address sees old data
        step(1, 4'd9, 32'hDEAD_BEEF, 4'hF, 0, 0, '0, '0, '0, 0, 0);
        step(1, 4'd9, 32'h0BAD_F00D, 4'hF, 0, 0, 4'd9, '0, '0, 1, 0);
        step(0, 4'd9, '0, '0, 0, 1, 4'd9, 32'h5555_AAAA, 4'hF, 0, 0);
        step(0, 4'd9, '0, '0, 1, 0, '0, '0, '0, 0, 0);

        // Isolated read pulse for latency
        idle(3);
        step(0, 4'd3, '0, '0, 1, 0, '0, '0, '0, 0, 0);
        idle(3);

        // Random traffic; both ports never write the same address together
        for (int i = 0; i < 300; i++) begin
            wa = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            aa = 4'($urandom_range(0, DEPTH - 1));
            ab = 4'($urandom_range(0, DEPTH - 1));
            if (wa && wb && ab == aa) ab = aa + 4'd1;
            step(wa, aa, $urandom, 4'($urandom_range(0, 15)), ra,
                 wb, ab, $urandom, 4'($urandom_range(0, 15)), rb, 0);
        end
        idle(3);

        // Clear request mid-traffic; writes while busy are lost, repeat requests ignored
        step(1, 4'd2, 32'h0102_0304, 4'hF, 1, 1, 4'd4, 32'hCAFE_0004, 4'hF, 1, 1);
        for (int i = 0; i < 6; i++)
            step(1, 4'd1, 32'h0BAD_0BAD, 4'hF, 1, 1, 4'd2, 32'h0BAD_0002, 4'hF, 1, (i == 2));

        // Reset mid-clear restarts the clear
        apply_reset();
        idle(DEPTH);
        step(0, 4'd1, '0, '0, 1, 0, 4'd2, '0, '0, 1, 0);
        step(0, 4'd4, '0, '0, 1, 0, 4'd0, '0, '0, 1, 0);

`ifdef VFIFO_RAM_PARITY_EN
        // Flip one stored data bit; the read flags a parity error
        step(1, 4'd3, 32'h1357_9BDF, 4'hF, 0, 0, '0, '0, '0, 0, 0);
        idle(1);
        dut0.mem[3][0] = ~dut0.mem[3][0];
        dut1.mem[3][0] = ~dut1.mem[3][0];
        m[3][0]        = ~m[3][0];
        corrupt[3]     = 1'b1;
        step(0, 4'd3, '0, '0, 1, 0, 4'd3, '0, '0, 1, 0);
        step(0, 4'd4, '0, '0, 1, 0, '0, '0, '0, 0, 0);
`endif

        idle(4);
        for (int s = 0; s < 4; s++) check($sformatf("drain%0d", s), 32'(exp_q[s].size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
